// File: rtl/uart_tx_top_ctl_pkg.sv
// Shared UART TX definitions: FSM encodings, frame constants and frame-size helper.
package uart_tx_top_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5
  } tx_state_e;

  localparam int   UART_DATA_BITS   = 8;
  localparam int   DEFAULT_BAUD_DIV = 5208;
  localparam logic START_BIT_LVL    = 1'b0;
  localparam logic STOP_BIT_LVL     = 1'b1;

  // Bits in one frame including the start bit.
  function automatic int frame_bits(input int stop_bits);
    return 1 + UART_DATA_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_top_ctl_if.sv
// TX FIFO read port: the transmitter is the master issuing read strobes.
interface uart_tx_top_ctl_if;
  import uart_tx_top_ctl_pkg::*;

  logic                      Empty_Sig;
  logic                      Read_Req_Sig;
  logic [UART_DATA_BITS-1:0] FIFO_Read_Data;

  modport master (output Read_Req_Sig, input Empty_Sig, input FIFO_Read_Data);
  modport slave  (input Read_Req_Sig, output Empty_Sig, output FIFO_Read_Data);
endinterface

// File: rtl/uart_tx_top_ctl_shifter.sv
// Baud-timed frame serialiser: start bit, 8 data bits LSB first, STOP_BITS stop bits.
module uart_tx_top_ctl_shifter
  import uart_tx_top_ctl_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Start_Sig,
  input  logic [UART_DATA_BITS-1:0] Data,
  output logic                      Pin_Out,
  output logic                      Done_Sig
);

  localparam int               FRAME_BITS = frame_bits(STOP_BITS);
  localparam int               CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       IDX_LAST   = 4'(FRAME_BITS - 1);

  logic                  active_q;
  logic [CNT_W-1:0]      baud_cnt_q;
  logic [3:0]            bit_idx_q;
  logic [FRAME_BITS-2:0] shift_q;   // bits still to go out after the start bit
  logic                  pin_q;
  logic                  bit_end;

  assign bit_end  = active_q && (baud_cnt_q == CNT_LAST);
  // Combinational so the controller leaves SEND in the last stop-bit cycle.
  assign Done_Sig = bit_end && (bit_idx_q == IDX_LAST);
  assign Pin_Out  = pin_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q   <= 1'b0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      pin_q      <= STOP_BIT_LVL;
    end else if (Start_Sig) begin
      active_q   <= 1'b1;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= {{STOP_BITS{STOP_BIT_LVL}}, Data};
      pin_q      <= START_BIT_LVL;
    end else if (active_q) begin
      if (bit_end) begin
        baud_cnt_q <= '0;
        if (bit_idx_q == IDX_LAST) begin
          active_q <= 1'b0;
          pin_q    <= STOP_BIT_LVL;
        end else begin
          bit_idx_q <= bit_idx_q + 4'd1;
          pin_q     <= shift_q[0];
          shift_q   <= {STOP_BIT_LVL, shift_q[FRAME_BITS-2:1]};
        end
      end else begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_top_ctl.sv
// UART transmit controller: drains the TX FIFO one byte per frame and drives the shifter.
module uart_tx_top_ctl
  import uart_tx_top_ctl_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TX_En_Sig,
  uart_tx_top_ctl_if.master fifo,
  output logic              TX_Pin_Out,
  output logic              TX_Busy_Sig,
  output logic              TX_Done_Sig
);

  tx_state_e state_q, state_d;
  logic      read_req_q;
  logic      busy_q;
  logic      done_q;
  logic      shift_start;
  logic      shift_done;

  // NOTE: state_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (TX_En_Sig && !fifo.Empty_Sig) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_LOAD;  // registered FIFO: data valid this cycle
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (shift_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      read_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_req_q <= (state_d == ST_REQ);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign shift_start       = (state_q == ST_LOAD);
  assign fifo.Read_Req_Sig = read_req_q;
  assign TX_Busy_Sig       = busy_q;
  assign TX_Done_Sig       = done_q;

  uart_tx_top_ctl_shifter #(
    .BAUD_DIV  (BAUD_DIV),
    .STOP_BITS (STOP_BITS)
  ) u_shifter (
    .CLK       (CLK),
    .RST       (RST),
    .Start_Sig (shift_start),
    .Data      (fifo.FIFO_Read_Data),
    .Pin_Out   (TX_Pin_Out),
    .Done_Sig  (shift_done)
  );

endmodule

// File: tb/tb_uart_tx_top_ctl.sv
// Directed bench for uart_tx_top_ctl: 8N1 at BAUD_DIV=4 plus one 8N2 frame at BAUD_DIV=5208.
module tb_uart_tx_top_ctl;
  import uart_tx_top_ctl_pkg::*;

  localparam int B      = 4;
  localparam int B_SLOW = 5208;
  localparam int LEN_2S = 11 * B_SLOW;  // 57288

  logic CLK  = 1'b0;
  logic RST  = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic pin_a, busy_a, done_a;
  logic pin_b, busy_b, done_b;

  int checks   = 0;
  int failures = 0;

  uart_tx_top_ctl_if a_if ();
  uart_tx_top_ctl_if b_if ();

  uart_tx_top_ctl #(.BAUD_DIV(B), .STOP_BITS(1)) dut_a (
    .CLK (CLK), .RST (RST), .TX_En_Sig (en_a), .fifo (a_if),
    .TX_Pin_Out (pin_a), .TX_Busy_Sig (busy_a), .TX_Done_Sig (done_a)
  );

  uart_tx_top_ctl #(.BAUD_DIV(B_SLOW), .STOP_BITS(2)) dut_b (
    .CLK (CLK), .RST (RST), .TX_En_Sig (en_b), .fifo (b_if),
    .TX_Pin_Out (pin_b), .TX_Busy_Sig (busy_b), .TX_Done_Sig (done_b)
  );

  always #5 CLK = ~CLK;

  // Registered, non-show-ahead FIFO models
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic       a_empty = 1'b1, b_empty = 1'b1;
  logic [7:0] a_rdata = '0,   b_rdata = '0;

  assign a_if.Empty_Sig      = a_empty;
  assign a_if.FIFO_Read_Data = a_rdata;
  assign b_if.Empty_Sig      = b_empty;
  assign b_if.FIFO_Read_Data = b_rdata;

  always @(posedge CLK) begin
    if (a_if.Read_Req_Sig && a_q.size() > 0) a_rdata <= a_q.pop_front();
    a_empty <= (a_q.size() == 0);
    if (b_if.Read_Req_Sig && b_q.size() > 0) b_rdata <= b_q.pop_front();
    b_empty <= (b_q.size() == 0);
  end

  // Event counters for instance a, sampled mid-cycle
  int req_cnt = 0, done_cnt = 0, low_cnt = 0, overlap_cnt = 0;
  always @(negedge CLK) begin
    if (a_if.Read_Req_Sig) req_cnt++;
    if (done_a) done_cnt++;
    if (!pin_a) low_cnt++;
    if (a_if.Read_Req_Sig && done_a) overlap_cnt++;
  end

  // Decode one 8N1 frame from pin_a. gap = high samples before the start bit,
  // req_at = sample index of the last read strobe seen while waiting (-1 if none).
  task automatic rx_frame(output logic [7:0] data, output bit ok, output int gap, output int req_at);
    bit   found = 0;
    logic lvl   = 1'b1;
    ok = 1; gap = 0; req_at = -1; data = '0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge CLK);
      if (a_if.Read_Req_Sig) req_at = gap;
      if (!pin_a) found = 1;
      else gap++;
    end
    if (!found) begin
      ok = 0;
      return;
    end
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < B; k++) begin
        if (i != 0 || k != 0) @(negedge CLK);
        if (k == 0) lvl = pin_a;
        else if (pin_a !== lvl) ok = 0;
      end
      if (i == 0 && lvl !== 1'b0) ok = 0;
      else if (i >= 1 && i <= 8) data[i-1] = lvl;
      else if (i == 9 && lvl !== 1'b1) ok = 0;
    end
  endtask

  task automatic test_reset;
    int r0, d0, l0;
    RST = 1'b1; en_a = 1'b1; en_b = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (pin_a !== 1'b1) begin failures++; $display("FAIL reset_pin: got %b want 1", pin_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (a_if.Read_Req_Sig !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", a_if.Read_Req_Sig); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_a); end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); r0 = req_cnt; d0 = done_cnt; l0 = low_cnt;
    repeat (100) @(posedge CLK);
    checks++; if (req_cnt - r0 != 0) begin failures++; $display("FAIL empty_req: got %0d pulses want 0", req_cnt - r0); end
    checks++; if (done_cnt - d0 != 0) begin failures++; $display("FAIL empty_done: got %0d pulses want 0", done_cnt - d0); end
    checks++; if (low_cnt - l0 != 0) begin failures++; $display("FAIL empty_line: got %0d low cycles want 0", low_cnt - l0); end
  endtask

  task automatic test_single_frame;
    int r0, d0, gap, req_at;
    logic [7:0] data;
    bit ok;
    @(posedge CLK); r0 = req_cnt; d0 = done_cnt;
    @(negedge CLK); a_q.push_back(8'hA5);
    rx_frame(data, ok, gap, req_at);
    checks++; if (!ok) begin failures++; $display("FAIL a5_framing: got bad frame want 0,1,0,1,0,0,1,0,1,1"); end
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL a5_data: got %h want a5", data); end
    // Read strobe in cycle 1, start bit in cycle 4
    checks++; if (req_at < 0 || gap - req_at != 3) begin failures++; $display("FAIL a5_latency: got req_at=%0d start=%0d want start-req=3", req_at, gap); end
    @(negedge CLK);
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL a5_done_at_40: got %b want 1", done_a); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL a5_busy_in_done: got %b want 1", busy_a); end
    @(negedge CLK);
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL a5_idle_after: got done=%b busy=%b want 0,0", done_a, busy_a); end
    @(posedge CLK);
    checks++; if (req_cnt - r0 != 1) begin failures++; $display("FAIL a5_req_count: got %0d want 1", req_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL a5_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[3] = '{8'h00, 8'hFF, 8'h3C};
    int r0, d0, gap, req_at;
    logic [7:0] data;
    bit ok;
    @(posedge CLK); r0 = req_cnt; d0 = done_cnt;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) a_q.push_back(exp_b[i]);
    for (int i = 0; i < 3; i++) begin
      rx_frame(data, ok, gap, req_at);
      checks++; if (!ok || data !== exp_b[i]) begin failures++; $display("FAIL b2b_frame%0d: got %h ok=%0d want %h", i, data, ok, exp_b[i]); end
      if (i > 0) begin
        checks++; if (gap != 5) begin failures++; $display("FAIL b2b_gap%0d: got %0d want 5", i, gap); end
      end
    end
    repeat (20) @(negedge CLK);
    @(posedge CLK);
    checks++; if (req_cnt - r0 != 3) begin failures++; $display("FAIL b2b_req_count: got %0d want 3", req_cnt - r0); end
    checks++; if (done_cnt - d0 != 3) begin failures++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
  endtask

  task automatic test_enable_drop;
    int r0, d0, l0, gap, req_at;
    logic [7:0] data;
    bit ok;
    @(posedge CLK); r0 = req_cnt; d0 = done_cnt; l0 = low_cnt;
    @(negedge CLK);
    a_q.push_back(8'h55); a_q.push_back(8'h11); a_q.push_back(8'h22);
    fork
      rx_frame(data, ok, gap, req_at);
      begin
        bit seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge CLK);
          if (!pin_a) seen = 1;
        end
        repeat (4 * B + 1) @(negedge CLK);  // middle of data bit 3
        en_a = 1'b0;
      end
    join
    checks++; if (!ok || data !== 8'h55) begin failures++; $display("FAIL endrop_frame: got %h ok=%0d want 55", data, ok); end
    @(negedge CLK);
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL endrop_done: got %b want 1", done_a); end
    repeat (60) @(negedge CLK);
    @(posedge CLK);
    checks++; if (req_cnt - r0 != 1) begin failures++; $display("FAIL endrop_req_count: got %0d want 1", req_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL endrop_done_count: got %0d want 1", done_cnt - d0); end
    // 0x55 frame has 5 low bits (start, D1, D3, D5, D7)
    checks++; if (low_cnt - l0 != 5 * B) begin failures++; $display("FAIL endrop_low_cycles: got %0d want %0d", low_cnt - l0, 5 * B); end
  endtask

  task automatic test_reset_mid_frame;
    int gap, req_at;
    logic [7:0] data;
    bit ok;
    bit seen = 0;
    @(negedge CLK); en_a = 1'b1;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge CLK);
      if (!pin_a) seen = 1;
    end
    repeat (6 * B + 2) @(negedge CLK);  // middle of data bit 5 of 0x11 (a 0)
    checks++; if (pin_a !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got pin=%b busy=%b want 0,1", pin_a, busy_a); end
    #1 RST = 1'b1;
    #1;
    checks++; if (pin_a !== 1'b1) begin failures++; $display("FAIL rstmid_pin: got %b want 1", pin_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    rx_frame(data, ok, gap, req_at);
    checks++; if (!ok || data !== 8'h22) begin failures++; $display("FAIL rstmid_next_frame: got %h ok=%0d want 22", data, ok); end
    @(negedge CLK);
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL rstmid_done: got %b want 1", done_a); end
  endtask

  task automatic test_two_stop_bits;
    logic [10:0] got;
    logic [10:0] exp_bits;
    int early = 0;
    bit seen  = 0;
    exp_bits = {2'b11, 8'h81, 1'b0};
    got      = '0;
    @(negedge CLK); b_q.push_back(8'h81); en_b = 1'b1;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge CLK);
      if (!pin_b) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL 2stop_start: got no start bit want start within 100 clk"); end
    got[0] = pin_b;
    for (int t = 1; t <= LEN_2S; t++) begin
      @(negedge CLK);
      if (t % B_SLOW == B_SLOW / 2) got[t / B_SLOW] = pin_b;
      if (t < LEN_2S && done_b) early++;
      if (t == LEN_2S) begin
        checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL 2stop_done_at_len: got %b want 1 at clk %0d", done_b, LEN_2S); end
      end
    end
    checks++; if (early != 0) begin failures++; $display("FAIL 2stop_early_done: got %0d early pulses want 0", early); end
    checks++; if (got !== exp_bits) begin failures++; $display("FAIL 2stop_bits: got %b want %b", got, exp_bits); end
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_two_stop_bits();
    @(posedge CLK);
    checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL req_done_overlap: got %0d cycles want 0", overlap_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
